udp_cmd_decoder: RTL and testbench
==================================

// Module: udp_cmd_decoder
// PURPOSE
//   Host->FPGA control path: parses UDP payload words from the udp receiver (data_o_valid/ram_wr_data)
//   as fixed 3-word command frames, validates magic + checksum, and updates the NCO phase increment,
//   the TX trigger period, and one-shot TX trigger requests consumed by the sample/transmit logic.
//   Runs in the e_rxc domain; outputs crossing to fpga_gclk are synchronised by the consumer.
// PARAMETERS
//   PHI_W          7         width of phi_inc_o
//   PHI_DEFAULT    7'd82     phi_inc_o reset value
//   PERIOD_W       20        width of period_o
//   PERIOD_DEFAULT 20'hffff7 period_o reset value
//   MAGIC          16'hA55A  required word0[31:16]
//   ERR_W          8         width of err_count_o (saturating)
// PORTS
//   e_rxc          in   1        125 MHz rx clock (sole clock)
//   reset_n        in   1        asynchronous, active-low reset
//   pkt_sop        in   1        1-cycle pulse: new UDP payload begins (may coincide with word0)
//   pkt_eop        in   1        1-cycle pulse: payload ended (after last data_o_valid)
//   data_o_valid   in   1        ram_wr_data holds a payload word this cycle
//   ram_wr_data    in   32       payload word, big-endian
//   phi_inc_o      out  PHI_W    NCO phase increment
//   period_o       out  PERIOD_W TX trigger period (gclk counts)
//   trig_o         out  1        1-cycle TX trigger request
//   cmd_ok_o       out  1        1-cycle pulse: command executed
//   cmd_err_o      out  1        1-cycle pulse: frame rejected
//   err_count_o    out  ERR_W    rejected-frame count, saturates at all-ones
//   last_seq_o     out  8        seq field of last executed command
// BEHAVIOUR
//   Frame: w0={MAGIC,cmd[7:0],seq[7:0]}, w1=arg[31:0], w2={16'h0,csum}.
//   csum = ~(w0[31:16]+w0[15:0]+w1[31:16]+w1[15:0]) mod 2^16; w2[31:16] ignored.
//   Commands: 8'h01 SET_PHI phi_inc_o<=arg[PHI_W-1:0]; 8'h02 TRIG trig_o pulse;
//     8'h03 SET_PERIOD period_o<=arg[PERIOD_W-1:0]; 8'h04 CLR_ERR err_count_o<=0. Other cmd -> error.
//   Reset: IDLE; phi_inc_o=PHI_DEFAULT, period_o=PERIOD_DEFAULT, trig/ok/err pulses 0,
//     err_count_o=0, last_seq_o=0. Reset mid-frame discards the frame, no pulse.
//   FSM: IDLE -pkt_sop-> HDR; HDR -valid: magic ok->ARG, bad->ERR; ARG -valid-> CSUM;
//     CSUM -valid: csum ok & cmd known->EXEC, else ERR; EXEC/ERR (1 cycle) -> DRAIN; DRAIN -pkt_eop-> IDLE.
//   pkt_sop with data_o_valid same cycle: word is w0 (check magic that cycle, go ARG/ERR).
//   Latency: csum word sampled at edge N; EXEC at N..N+1; registered outputs/pulses visible after edge N+1
//     (2 edges after csum sample). Pulses last exactly 1 cycle.
//   pkt_eop in HDR/ARG/CSUM (short frame) -> ERR then IDLE (DRAIN skipped since eop consumed).
//   pkt_sop in ARG/CSUM/DRAIN: abort; ARG/CSUM abort counts as error (cmd_err_o pulse); restart at HDR.
//   Words beyond w2 ignored in DRAIN; data_o_valid in IDLE ignored.
//   err_count_o increments once per ERR, saturates; CLR_ERR in same frame is not itself an error.
//   last_seq_o updated only in EXEC. Cmd fields never partially applied on error.
// TESTING
//   1 SET_PHI: sop, w0=A55A0101, w1=00000030, w2=00005974, eop -> phi_inc_o=7'h30, cmd_ok_o 1 pulse,
//     last_seq_o=01, 2 edges after w2.
//   2 Bad csum: same frame w2=00005975 -> phi_inc_o stays 82, cmd_err_o pulse, err_count_o=1.
//   3 TRIG: w0=A55A0207, w1=0, w2=~(A55A+0207)=58 9E -> 0000589E -> trig_o exactly 1 cycle, seq 07.
//   4 Short frame: sop, w0 valid, eop -> cmd_err_o, err_count_o+1, FSM IDLE; next valid frame executes.
//   5 Restart: sop, w0, then sop+w0 of frame 1 data -> one error counted, then frame executes normally.
//   6 Saturation/reset: 260 bad-magic frames -> err_count_o=FF; assert reset_n mid-frame -> all defaults.

Source files
------------

// File: rtl/udp_cmd_decoder.sv
// Host command decoder: parses 3-word UDP command frames (magic, arg, checksum)
// and updates NCO phase increment, TX trigger period and one-shot trigger requests.
module udp_cmd_decoder #(
    parameter int                  PHI_W          = 7,
    parameter logic [PHI_W-1:0]    PHI_DEFAULT    = 7'd82,
    parameter int                  PERIOD_W       = 20,
    parameter logic [PERIOD_W-1:0] PERIOD_DEFAULT = 20'hffff7,
    parameter logic [15:0]         MAGIC          = 16'hA55A,
    parameter int                  ERR_W          = 8
) (
    input  logic                e_rxc,
    input  logic                reset_n,
    input  logic                pkt_sop,
    input  logic                pkt_eop,
    input  logic                data_o_valid,
    input  logic [31:0]         ram_wr_data,
    output logic [PHI_W-1:0]    phi_inc_o,
    output logic [PERIOD_W-1:0] period_o,
    output logic                trig_o,
    output logic                cmd_ok_o,
    output logic                cmd_err_o,
    output logic [ERR_W-1:0]    err_count_o,
    output logic [7:0]          last_seq_o
);

    // state  | meaning
    // IDLE   | waiting for pkt_sop
    // HDR    | waiting for word0 (magic/cmd/seq)
    // ARG    | waiting for word1 (argument)
    // CSUM   | waiting for word2 (checksum)
    // EXEC   | apply command (1 cycle)
    // ERR    | reject frame (1 cycle)
    // DRAIN  | discard remaining words until pkt_eop
    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_ARG, S_CSUM, S_EXEC, S_ERR, S_DRAIN
    } state_t;

    localparam logic [7:0] CMD_SET_PHI    = 8'h01;
    localparam logic [7:0] CMD_TRIG       = 8'h02;
    localparam logic [7:0] CMD_SET_PERIOD = 8'h03;
    localparam logic [7:0] CMD_CLR_ERR    = 8'h04;

    state_t              state, state_nx;
    logic [7:0]          cmd_r, seq_r;
    logic [PERIOD_W-1:0] arg_r;
    logic [15:0]         sum_r;
    logic                eop_seen, eop_nx;
    logic                ld_w0, ld_w1, err_now;
    logic                magic_ok, csum_ok, cmd_known;

    assign magic_ok  = (ram_wr_data[31:16] == MAGIC);
    assign csum_ok   = (ram_wr_data[15:0] == ~sum_r);
    assign cmd_known = (cmd_r >= CMD_SET_PHI) && (cmd_r <= CMD_CLR_ERR);

    always_comb begin
        state_nx = state;
        eop_nx   = 1'b0;
        ld_w0    = 1'b0;
        ld_w1    = 1'b0;
        err_now  = (state == S_ERR);
        if (pkt_sop) begin
            // A new payload always restarts parsing; abandoning a half-parsed frame is an error.
            if (state == S_ARG || state == S_CSUM)
                err_now = 1'b1;
            if (data_o_valid) begin
                state_nx = magic_ok ? S_ARG : S_ERR;
                ld_w0    = magic_ok;
                eop_nx   = pkt_eop;
            end else begin
                state_nx = S_HDR;
            end
        end else begin
            case (state)
                S_IDLE: state_nx = S_IDLE;
                S_HDR: begin
                    if (data_o_valid) begin
                        state_nx = magic_ok ? S_ARG : S_ERR;
                        ld_w0    = magic_ok;
                        eop_nx   = pkt_eop;
                    end else if (pkt_eop) begin
                        state_nx = S_ERR;
                        eop_nx   = 1'b1;
                    end
                end
                S_ARG: begin
                    if (data_o_valid) begin
                        state_nx = S_CSUM;
                        ld_w1    = 1'b1;
                    end else if (pkt_eop) begin
                        state_nx = S_ERR;
                        eop_nx   = 1'b1;
                    end
                end
                S_CSUM: begin
                    if (data_o_valid) begin
                        state_nx = (csum_ok && cmd_known) ? S_EXEC : S_ERR;
                        eop_nx   = pkt_eop;
                    end else if (pkt_eop) begin
                        state_nx = S_ERR;
                        eop_nx   = 1'b1;
                    end
                end
                S_EXEC, S_ERR: state_nx = (eop_seen || pkt_eop) ? S_IDLE : S_DRAIN;
                S_DRAIN: if (pkt_eop) state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge e_rxc or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            eop_seen <= 1'b0;
            cmd_r    <= '0;
            seq_r    <= '0;
            arg_r    <= '0;
            sum_r    <= '0;
        end else begin
            state    <= state_nx;
            eop_seen <= eop_nx;
            if (ld_w0) begin
                cmd_r <= ram_wr_data[15:8];
                seq_r <= ram_wr_data[7:0];
                sum_r <= ram_wr_data[31:16] + ram_wr_data[15:0];
            end
            if (ld_w1) begin
                arg_r <= ram_wr_data[PERIOD_W-1:0];
                sum_r <= sum_r + ram_wr_data[31:16] + ram_wr_data[15:0];
            end
        end
    end

    always_ff @(posedge e_rxc or negedge reset_n) begin
        if (!reset_n) begin
            phi_inc_o   <= PHI_DEFAULT;
            period_o    <= PERIOD_DEFAULT;
            trig_o      <= 1'b0;
            cmd_ok_o    <= 1'b0;
            cmd_err_o   <= 1'b0;
            err_count_o <= '0;
            last_seq_o  <= '0;
        end else begin
            trig_o    <= (state == S_EXEC) && (cmd_r == CMD_TRIG);
            cmd_ok_o  <= (state == S_EXEC);
            cmd_err_o <= err_now;
            if (err_now && (err_count_o != {ERR_W{1'b1}}))
                err_count_o <= err_count_o + 1'b1;
            if (state == S_EXEC) begin
                last_seq_o <= seq_r;
                case (cmd_r)
                    CMD_SET_PHI:    phi_inc_o   <= arg_r[PHI_W-1:0];
                    CMD_SET_PERIOD: period_o    <= arg_r;
                    CMD_CLR_ERR:    err_count_o <= '0;
                    default:        ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_udp_cmd_decoder.sv
// Scoreboard bench for udp_cmd_decoder: a reference model predicts each ok/err pulse
// and the register state visible with it.
module tb_udp_cmd_decoder;

    logic        e_rxc = 1'b0;
    logic        reset_n = 1'b0;
    logic        pkt_sop = 1'b0, pkt_eop = 1'b0, data_o_valid = 1'b0;
    logic [31:0] ram_wr_data = '0;
    logic [6:0]  phi_inc_o;
    logic [19:0] period_o;
    logic        trig_o, cmd_ok_o, cmd_err_o;
    logic [7:0]  err_count_o, last_seq_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        ok;
        logic        trig;
        logic [6:0]  phi;
        logic [19:0] period;
        logic [7:0]  seq;
        logic [7:0]  errcnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        sb_e;
    logic [6:0]  m_phi;
    logic [19:0] m_period;
    logic [7:0]  m_seq, m_errcnt;

    udp_cmd_decoder dut (
        .e_rxc(e_rxc), .reset_n(reset_n), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop),
        .data_o_valid(data_o_valid), .ram_wr_data(ram_wr_data),
        .phi_inc_o(phi_inc_o), .period_o(period_o), .trig_o(trig_o),
        .cmd_ok_o(cmd_ok_o), .cmd_err_o(cmd_err_o),
        .err_count_o(err_count_o), .last_seq_o(last_seq_o)
    );

    always #4 e_rxc = ~e_rxc;

    always @(negedge e_rxc) begin
        if (reset_n && (cmd_ok_o || cmd_err_o)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_pulse ok=%0b err=%0b required none", cmd_ok_o, cmd_err_o);
            end else begin
                sb_e = sb.pop_front();
                if (cmd_ok_o !== sb_e.ok || cmd_err_o !== !sb_e.ok || trig_o !== sb_e.trig ||
                    phi_inc_o !== sb_e.phi || period_o !== sb_e.period ||
                    last_seq_o !== sb_e.seq || err_count_o !== sb_e.errcnt) begin
                    errors++;
                    $display("FAIL sb_result got ok=%0b err=%0b trig=%0b phi=%h per=%h seq=%h ec=%h required ok=%0b err=%0b trig=%0b phi=%h per=%h seq=%h ec=%h",
                             cmd_ok_o, cmd_err_o, trig_o, phi_inc_o, period_o, last_seq_o, err_count_o,
                             sb_e.ok, !sb_e.ok, sb_e.trig, sb_e.phi, sb_e.period, sb_e.seq, sb_e.errcnt);
                end
            end
        end else if (reset_n && trig_o) begin
            checks++;
            errors++;
            $display("FAIL sb_spurious_trig got trig=1 required 0");
        end
    end

    function automatic logic [15:0] csum(input logic [31:0] w0, input logic [31:0] w1);
        logic [15:0] s;
        s = w0[31:16] + w0[15:0] + w1[31:16] + w1[15:0];
        return ~s;
    endfunction

    task automatic model_reset();
        m_phi = 7'd82; m_period = 20'hffff7; m_seq = 8'h00; m_errcnt = 8'h00;
    endtask

    task automatic expect_err();
        exp_t e;
        if (m_errcnt != 8'hff) m_errcnt = m_errcnt + 8'd1;
        e = '{ok: 1'b0, trig: 1'b0, phi: m_phi, period: m_period, seq: m_seq, errcnt: m_errcnt};
        sb.push_back(e);
    endtask

    task automatic expect_frame(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        exp_t e;
        if (w0[31:16] != 16'hA55A || w2[15:0] != csum(w0, w1) || w0[15:8] < 8'h01 || w0[15:8] > 8'h04) begin
            expect_err();
        end else begin
            case (w0[15:8])
                8'h01: m_phi = w1[6:0];
                8'h03: m_period = w1[19:0];
                8'h04: m_errcnt = 8'h00;
                default: ;
            endcase
            m_seq = w0[7:0];
            e = '{ok: 1'b1, trig: (w0[15:8] == 8'h02), phi: m_phi, period: m_period, seq: m_seq, errcnt: m_errcnt};
            sb.push_back(e);
        end
    endtask

    task automatic drive(input logic sop, input logic eop, input logic vld, input logic [31:0] d);
        pkt_sop = sop; pkt_eop = eop; data_o_valid = vld; ram_wr_data = d;
        @(posedge e_rxc); #1;
        pkt_sop = 1'b0; pkt_eop = 1'b0; data_o_valid = 1'b0; ram_wr_data = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge e_rxc); #1; end
    endtask

    // Returns one edge after the EXEC/ERR cycle, i.e. when the result is visible.
    task automatic send_frame(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        expect_frame(w0, w1, w2);
        drive(1, 0, 0, 0);
        drive(0, 0, 1, w0);
        drive(0, 0, 1, w1);
        drive(0, 0, 1, w2);
        drive(0, 1, 0, 0);
    endtask

    task automatic wait_sb();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin idle(1); n++; end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL sb_timeout got pending=%0d required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        idle(2);
        checks++;
        if (phi_inc_o !== 7'd82 || period_o !== 20'hffff7 || err_count_o !== 8'h00 || last_seq_o !== 8'h00 ||
            trig_o !== 1'b0 || cmd_ok_o !== 1'b0 || cmd_err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got phi=%h per=%h ec=%h seq=%h required 52 ffff7 00 00", phi_inc_o, period_o, err_count_o, last_seq_o);
        end
        reset_n = 1'b1;
        idle(2);
    endtask

    task automatic test_bad_csum();
        send_frame(32'hA55A0101, 32'h00000030, 32'h00005975);
        checks++;
        if (cmd_err_o !== 1'b1 || phi_inc_o !== 7'd82 || err_count_o !== 8'd1) begin
            errors++;
            $display("FAIL bad_csum got err=%0b phi=%h ec=%h required 1 52 01", cmd_err_o, phi_inc_o, err_count_o);
        end
        wait_sb();
    endtask

    task automatic test_set_phi();
        send_frame(32'hA55A0101, 32'h00000030, 32'h00005974);
        checks++;
        if (cmd_ok_o !== 1'b1 || phi_inc_o !== 7'h30 || last_seq_o !== 8'h01) begin
            errors++;
            $display("FAIL set_phi_latency got ok=%0b phi=%h seq=%h required 1 30 01", cmd_ok_o, phi_inc_o, last_seq_o);
        end
        idle(1);
        checks++;
        if (cmd_ok_o !== 1'b0) begin
            errors++;
            $display("FAIL set_phi_pulse_width got ok=%0b required 0", cmd_ok_o);
        end
        wait_sb();
        send_frame(32'hA55A0102, 32'h000000FF, {16'hBEEF, csum(32'hA55A0102, 32'h000000FF)});
        wait_sb();
    endtask

    task automatic test_trig();
        send_frame(32'hA55A0207, 32'h00000000, 32'h0000589E);
        checks++;
        if (trig_o !== 1'b1 || last_seq_o !== 8'h07) begin
            errors++;
            $display("FAIL trig_pulse got trig=%0b seq=%h required 1 07", trig_o, last_seq_o);
        end
        idle(1);
        checks++;
        if (trig_o !== 1'b0) begin
            errors++;
            $display("FAIL trig_width got trig=%0b required 0", trig_o);
        end
        wait_sb();
    endtask

    task automatic test_period_clr_unknown();
        send_frame(32'hA55A0310, 32'hABC12345, {16'h0, csum(32'hA55A0310, 32'hABC12345)});
        checks++;
        if (period_o !== 20'h12345) begin
            errors++;
            $display("FAIL set_period got %h required 12345", period_o);
        end
        wait_sb();
        send_frame(32'hA55A0511, 32'h00000001, {16'h0, csum(32'hA55A0511, 32'h00000001)});
        wait_sb();
        send_frame(32'hA55A0412, 32'h00000000, {16'h0, csum(32'hA55A0412, 32'h00000000)});
        checks++;
        if (err_count_o !== 8'h00) begin
            errors++;
            $display("FAIL clr_err got %h required 00", err_count_o);
        end
        wait_sb();
    endtask

    task automatic test_short_frame();
        expect_err();
        drive(1, 0, 1, 32'hA55A0120);
        drive(0, 1, 0, 0);
        idle(2);
        wait_sb();
        send_frame(32'hA55A0121, 32'h00000011, {16'h0, csum(32'hA55A0121, 32'h00000011)});
        checks++;
        if (cmd_ok_o !== 1'b1 || phi_inc_o !== 7'h11) begin
            errors++;
            $display("FAIL short_then_valid got ok=%0b phi=%h required 1 11", cmd_ok_o, phi_inc_o);
        end
        wait_sb();
    endtask

    task automatic test_restart();
        logic [31:0] w0, w1;
        w0 = 32'hA55A0133; w1 = 32'h00000055;
        expect_err();
        expect_frame(w0, w1, {16'h0, csum(w0, w1)});
        drive(1, 0, 1, 32'hA55A0299);
        drive(1, 0, 1, w0);
        drive(0, 0, 1, w1);
        drive(0, 0, 1, {16'h0, csum(w0, w1)});
        drive(0, 1, 0, 0);
        checks++;
        if (cmd_ok_o !== 1'b1 || phi_inc_o !== 7'h55 || last_seq_o !== 8'h33) begin
            errors++;
            $display("FAIL restart_exec got ok=%0b phi=%h seq=%h required 1 55 33", cmd_ok_o, phi_inc_o, last_seq_o);
        end
        wait_sb();
    endtask

    task automatic test_saturation_reset();
        for (int i = 0; i < 260; i++) begin
            expect_err();
            drive(1, 0, 1, 32'h12340100 | i[7:0]);
            drive(0, 1, 0, 0);
            idle(1);
        end
        wait_sb();
        checks++;
        if (err_count_o !== 8'hff) begin
            errors++;
            $display("FAIL err_saturate got %h required ff", err_count_o);
        end
        drive(1, 0, 1, 32'hA55A0140);
        pkt_eop = 1'b0; data_o_valid = 1'b1; ram_wr_data = 32'h00000007;
        #3 reset_n = 1'b0;
        model_reset();
        sb.delete();
        #1;
        checks++;
        if (phi_inc_o !== 7'd82 || period_o !== 20'hffff7 || err_count_o !== 8'h00 || last_seq_o !== 8'h00 ||
            cmd_ok_o !== 1'b0 || cmd_err_o !== 1'b0 || trig_o !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset got phi=%h per=%h ec=%h seq=%h required 52 ffff7 00 00", phi_inc_o, period_o, err_count_o, last_seq_o);
        end
        data_o_valid = 1'b0; ram_wr_data = '0;
        idle(2);
        reset_n = 1'b1;
        drive(0, 0, 1, {16'h0, csum(32'hA55A0140, 32'h00000007)});
        drive(0, 1, 0, 0);
        idle(4);
        send_frame(32'hA55A0141, 32'h00000009, {16'h0, csum(32'hA55A0141, 32'h00000009)});
        checks++;
        if (cmd_ok_o !== 1'b1 || phi_inc_o !== 7'h09 || err_count_o !== 8'h00) begin
            errors++;
            $display("FAIL after_reset got ok=%0b phi=%h ec=%h required 1 09 00", cmd_ok_o, phi_inc_o, err_count_o);
        end
        wait_sb();
    endtask

    initial begin
        test_reset();
        test_bad_csum();
        test_set_phi();
        test_trig();
        test_period_clr_unknown();
        test_short_frame();
        test_restart();
        test_saturation_reset();
        idle(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
